// File: rtl/zrb_spi_slave_pkg.sv
// Shared types and constants for the zrb SPI responder: FSM encoding and the
// default word returned when the host has nothing queued.
package zrb_spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10
    } spi_state_t;

    localparam logic [7:0] DEF_IDLE_WORD = 8'hFF;

endpackage

// File: rtl/zrb_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable
// value taken during reset so the idle level of the line is preserved.
module zrb_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/zrb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes when full and pops when
// empty are ignored, and dout shows the head whenever empty is low.
module zrb_sync_fifo #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_r [2**AW];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array, no reset needed since contents are gated by the pointers
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
    end

endmodule

// File: rtl/zrb_spi_slave.sv
// SPI mode-0 responder: oversamples sck/cs_n/mosi in the clk domain, shifts
// frames MSB first, and buffers traffic in host-visible TX and RX FIFOs.
module zrb_spi_slave
    import zrb_spi_slave_pkg::*;
#(
    parameter int                  NUM_BITS  = 8,
    parameter int                  FIFO_AW   = 2,
    parameter logic [NUM_BITS-1:0] IDLE_WORD = DEF_IDLE_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic                new_data,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                read_imp,
    output logic [NUM_BITS-1:0] data_out,
    output logic                tx_full,
    output logic                tx_empty,
    output logic                rx_full,
    output logic                rx_empty,
    output logic                busy,
    output logic                overrun,
    output logic                underrun,
    output logic                aborted
);

    localparam int             CW       = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(NUM_BITS);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

    logic                sck_s, cs_s, mosi_s;
    logic                sck_d_r, cs_d_r;
    logic                sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
    spi_state_t          state_r, state_nx_s;
    logic [NUM_BITS-1:0] tx_sh_r, rx_sh_r, tx_head_s, rx_word_s;
    logic [CW-1:0]       bit_cnt_r;
    logic                tx_pop_s, rx_push_s;
    logic                overrun_s, underrun_s, aborted_s;
    logic                miso_oe_r, overrun_r, underrun_r, aborted_r;

    zrb_sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(reset), .d(sck),  .q(sck_s));
    zrb_sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(reset), .d(cs_n), .q(cs_s));
    zrb_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(reset), .d(mosi), .q(mosi_s));

    zrb_sync_fifo #(.AW(FIFO_AW), .DW(NUM_BITS)) u_tx_fifo (
        .clk(clk), .rst_n(reset), .push(new_data), .din(data_in), .pop(tx_pop_s),
        .dout(tx_head_s), .full(tx_full), .empty(tx_empty)
    );

    zrb_sync_fifo #(.AW(FIFO_AW), .DW(NUM_BITS)) u_rx_fifo (
        .clk(clk), .rst_n(reset), .push(rx_push_s), .din(rx_word_s), .pop(read_imp),
        .dout(data_out), .full(rx_full), .empty(rx_empty)
    );

    assign sck_rise_s = sck_s & ~sck_d_r;
    assign sck_fall_s = ~sck_s & sck_d_r;
    assign cs_fall_s  = ~cs_s & cs_d_r;
    assign cs_rise_s  = cs_s & ~cs_d_r;
    assign rx_word_s  = {rx_sh_r[NUM_BITS-2:0], mosi_s};

    // Edge-detector delay stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_d_r <= 1'b0;
            cs_d_r  <= 1'b1;
        end else begin
            sck_d_r <= sck_s;
            cs_d_r  <= cs_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // FSM next state; deselect wins over any coincident sck edge
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (cs_fall_s) state_nx_s = ST_LOAD; else state_nx_s = ST_IDLE;
            ST_LOAD:  if (cs_rise_s) state_nx_s = ST_IDLE; else state_nx_s = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_rise_s)                                  state_nx_s = ST_IDLE;
                else if (sck_fall_s && (bit_cnt_r == CNT_ZERO)) state_nx_s = ST_LOAD;
                else                                            state_nx_s = ST_SHIFT;
            end
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO strobes and event pulses
    always_comb begin
        tx_pop_s    = 1'b0;
        rx_push_s   = 1'b0;
        overrun_s   = 1'b0;
        underrun_s  = 1'b0;
        aborted_s   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (!tx_empty) tx_pop_s   = 1'b1;
                else           underrun_s = 1'b1;
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    aborted_s = (bit_cnt_r != CNT_ZERO) && (bit_cnt_r != CNT_FULL);
                end else if (sck_rise_s && (bit_cnt_r == CNT_ONE)) begin
                    if (rx_full) overrun_s = 1'b1;
                    else         rx_push_s = 1'b1;
                end else begin
                    rx_push_s = 1'b0;
                end
            end
            default: tx_pop_s = 1'b0;
        endcase
    end

    // Shift registers and bit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sh_r   <= {NUM_BITS{1'b0}};
            rx_sh_r   <= {NUM_BITS{1'b0}};
            bit_cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    tx_sh_r   <= tx_empty ? IDLE_WORD : tx_head_s;
                    bit_cnt_r <= CNT_FULL;
                end
                ST_SHIFT: begin
                    if (!cs_rise_s && (bit_cnt_r != CNT_ZERO)) begin
                        if (sck_rise_s) begin
                            rx_sh_r   <= rx_word_s;
                            bit_cnt_r <= bit_cnt_r - CNT_ONE;
                        end else if (sck_fall_s) begin
                            tx_sh_r   <= {tx_sh_r[NUM_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: bit_cnt_r <= bit_cnt_r;
            endcase
        end
    end

    // Registered output enable and event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso_oe_r  <= 1'b0;
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            miso_oe_r  <= ~cs_s;
            overrun_r  <= overrun_s;
            underrun_r <= underrun_s;
            aborted_r  <= aborted_s;
        end
    end

    assign miso     = (state_r != ST_IDLE) ? tx_sh_r[NUM_BITS-1] : 1'b0;
    assign miso_oe  = miso_oe_r;
    assign busy     = (state_r != ST_IDLE);
    assign overrun  = overrun_r;
    assign underrun = underrun_r;
    assign aborted  = aborted_r;

endmodule

// File: tb/tb_zrb_spi_slave.sv
// Directed bench for zrb_spi_slave: a table of single/back-to-back frames
// plus hand-written overrun, abort and mid-frame reset sequences.
module tb_zrb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic       new_data = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_imp = 1'b0;
    logic [7:0] data_out;
    logic       tx_full, tx_empty, rx_full, rx_empty, busy;
    logic       overrun, underrun, aborted;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int un_cnt = 0;
    int ab_cnt = 0;

    zrb_spi_slave dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .new_data(new_data), .data_in(data_in),
        .read_imp(read_imp), .data_out(data_out), .tx_full(tx_full),
        .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .busy(busy), .overrun(overrun), .underrun(underrun), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (overrun)  ov_cnt++;
        if (underrun) un_cnt++;
        if (aborted)  ab_cnt++;
    end

    typedef struct {
        int         npre;
        logic [7:0] pre0;
        logic [7:0] pre1;
        int         nfr;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] e0;
        logic [7:0] e1;
        int         eund;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] w);
        new_data = 1'b1;
        data_in  = w;
        cycles(1);
        new_data = 1'b0;
    endtask

    task automatic pop_rx(input string name, input logic [7:0] exp);
        check({name, "_nonempty"}, rx_empty, 1'b0);
        check(name, data_out, exp);
        read_imp = 1'b1;
        cycles(1);
        read_imp = 1'b0;
    endtask

    // Master side: nbits MSB-first bits, miso sampled at each rising sck
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit end_cs,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            cycles(HALF);
            rx[7-i] = miso;
            sck = 1'b1;
            cycles(HALF);
            sck = 1'b0;
            if (end_cs && (i == nbits - 1)) cs_n = 1'b1;
        end
    endtask

    logic [7:0] got;
    int         u0, o0, a0;

    initial begin
        vecs[0] = '{1, 8'hA5, 8'h00, 1, 8'h3C, 8'h00, 8'hA5, 8'h00, 0};
        vecs[1] = '{2, 8'h11, 8'h22, 2, 8'hF0, 8'h0F, 8'h11, 8'h22, 0};
        vecs[2] = '{0, 8'h00, 8'h00, 1, 8'h55, 8'h00, 8'hFF, 8'h00, 1};
        vecs[3] = '{1, 8'hC3, 8'h00, 1, 8'h81, 8'h00, 8'hC3, 8'h00, 0};
        vecs[4] = '{1, 8'h7E, 8'h00, 2, 8'h01, 8'h80, 8'h7E, 8'hFF, 1};

        cycles(3);
        check("rst_miso", miso, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {tx_full, tx_empty, rx_full, rx_empty}, 4'b0101);
        check("rst_pulses", {overrun, underrun, aborted}, 3'b000);
        reset = 1'b1;
        cycles(4);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].npre > 0) push_tx(vecs[v].pre0);
            if (vecs[v].npre > 1) push_tx(vecs[v].pre1);
            u0 = un_cnt; o0 = ov_cnt; a0 = ab_cnt;
            cs_n = 1'b0;
            cycles(2);
            for (int f = 0; f < vecs[v].nfr; f++) begin
                spi_xfer((f == 0) ? vecs[v].m0 : vecs[v].m1, 8, f == vecs[v].nfr - 1, got);
                check($sformatf("v%0d_miso%0d", v, f), got, (f == 0) ? vecs[v].e0 : vecs[v].e1);
            end
            cycles(2 * HALF);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
            check($sformatf("v%0d_underrun", v), un_cnt - u0, vecs[v].eund);
            check($sformatf("v%0d_over_abort", v), (ov_cnt - o0) + (ab_cnt - a0), 0);
            check($sformatf("v%0d_tx_empty", v), tx_empty, 1'b1);
            pop_rx($sformatf("v%0d_rx0", v), vecs[v].m0);
            if (vecs[v].nfr > 1) pop_rx($sformatf("v%0d_rx1", v), vecs[v].m1);
            check($sformatf("v%0d_rx_drained", v), rx_empty, 1'b1);
        end

        // RX FIFO full, fifth word must be dropped
        for (int k = 1; k <= 4; k++) begin
            cs_n = 1'b0;
            cycles(2);
            spi_xfer(8'(k), 8, 1'b1, got);
            cycles(2 * HALF);
        end
        check("ovr_full_before", rx_full, 1'b1);
        o0 = ov_cnt;
        cs_n = 1'b0;
        cycles(2);
        spi_xfer(8'h99, 8, 1'b1, got);
        cycles(2 * HALF);
        check("ovr_pulse", ov_cnt - o0, 1);
        check("ovr_full_after", rx_full, 1'b1);
        for (int k = 1; k <= 4; k++) pop_rx($sformatf("ovr_rx%0d", k), 8'(k));
        check("ovr_drained", rx_empty, 1'b1);

        // Deselect after three sck periods
        a0 = ab_cnt;
        cs_n = 1'b0;
        cycles(2);
        spi_xfer(8'hE7, 3, 1'b0, got);
        cycles(HALF);
        cs_n = 1'b1;
        cycles(3);
        check("abt_miso_oe", miso_oe, 1'b0);
        check("abt_busy", busy, 1'b0);
        check("abt_miso", miso, 1'b0);
        cycles(2 * HALF);
        check("abt_pulse", ab_cnt - a0, 1);
        check("abt_rx_empty", rx_empty, 1'b1);
        push_tx(8'h4D);
        cs_n = 1'b0;
        cycles(2);
        spi_xfer(8'h6B, 8, 1'b1, got);
        check("abt_next_miso", got, 8'h4D);
        cycles(2 * HALF);
        pop_rx("abt_next_rx", 8'h6B);

        // Reset in the middle of a frame
        cs_n = 1'b0;
        cycles(2);
        spi_xfer(8'h77, 8, 1'b1, got);
        cycles(2 * HALF);
        push_tx(8'h12);
        push_tx(8'h34);
        cs_n = 1'b0;
        cycles(2);
        spi_xfer(8'hA0, 3, 1'b0, got);
        cycles(HALF / 2);
        check("rst_pre_miso", miso, 1'b1);
        reset = 1'b0;
        #1;
        check("mrst_miso", miso, 1'b0);
        check("mrst_miso_oe", miso_oe, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_empty", {tx_empty, rx_empty}, 2'b11);
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cycles(2);
        u0 = un_cnt; o0 = ov_cnt; a0 = ab_cnt;
        reset = 1'b1;
        cycles(20);
        check("mrst_no_pulses", (un_cnt - u0) + (ov_cnt - o0) + (ab_cnt - a0), 0);
        check("mrst_idle", {busy, miso_oe, tx_empty, rx_empty}, 4'b0011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zrb_spi_slave.md
Name: zrb_spi_slave

Overview:
- SPI responder (mode 0, MSB first, NUM_BITS-bit frames) that sits at the far end of the team's SPI master link. It is used for on-board bridges and for loop-back verification of the master.
- sck, cs_n and mosi are sampled through synchronisers into the local clk domain. Received words go into an RX FIFO; words to return go into a TX FIFO that the host preloads.
- Host-side handshake matches the master: new_data/data_in to write, read_imp/data_out to read, plus full/empty flags.

Parameters:
- NUM_BITS, 8, frame width in bits.
- FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW.
- IDLE_WORD, 8'hFF, word shifted out when the TX FIFO is empty. Width is NUM_BITS.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock from the master; asynchronous to clk.
- cs_n  in  1  chip select, active low; asynchronous.
- mosi  in  1  serial data from the master; asynchronous.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the external tri-state buffer.
- new_data  in  1  push data_in into the TX FIFO (one-cycle pulse).
- data_in  in  NUM_BITS  word to transmit.
- read_imp  in  1  pop the RX FIFO (one-cycle pulse).
- data_out  out  NUM_BITS  head of the RX FIFO.
- tx_full, tx_empty, rx_full, rx_empty  out  1 each  FIFO flags.
- busy  out  1  high while a frame is selected (state != IDLE).
- overrun  out  1  one-cycle pulse: a received word was dropped because the RX FIFO was full.
- underrun  out  1  one-cycle pulse: IDLE_WORD was loaded because the TX FIFO was empty.
- aborted  out  1  one-cycle pulse: cs_n rose while a word was partially shifted.

Behaviour:
- Reset (reset=0, asynchronous): all registers clear, state=IDLE, and both FIFOs are empty.
  - miso=0, miso_oe=0, busy=0, all pulse outputs 0.
  - Synchroniser outputs reset to sck=0, cs_n=1, mosi=0.
  - Reset asserted mid-frame discards everything with no pulses.
- Input sampling:
  - Each of sck, cs_n, mosi passes through a 2-FF synchroniser.
  - A third register on sck_s and cs_s drives the edge detectors: sck_rise, sck_fall, cs_fall, cs_rise.
  - Edge-to-action latency is 3 clk. Requirement on the master: sck high and low phases each last at least 4 clk periods, and cs_n-fall to first sck rise is at least 4 clk.
- State machine states: IDLE, LOAD, SHIFT.
  - IDLE: waits for cs_fall, then goes to LOAD.
  - LOAD (one cycle):
    - If the TX FIFO is not empty: tx_sh <= FIFO head, with a pop.
    - Otherwise: tx_sh <= IDLE_WORD and underrun pulses.
    - bit_cnt <= NUM_BITS; next state SHIFT.
  - SHIFT:
    - On sck_rise: rx_sh <= {rx_sh[NUM_BITS-2:0], mosi_s}; bit_cnt decrements.
    - When bit_cnt goes 1 -> 0, push {rx_sh[NUM_BITS-2:0], mosi_s} into the RX FIFO in the same cycle. If rx_full, drop the word and pulse overrun instead.
    - On sck_fall with bit_cnt != 0: tx_sh shifts left by 1.
    - On sck_fall with bit_cnt == 0: go to LOAD (back-to-back frame).
    - On cs_rise: go to IDLE. Pulse aborted only if 0 < bit_cnt < NUM_BITS. A popped-but-unsent TX word is lost, and the partial RX word is discarded.
- cs_rise has priority over simultaneous sck edges.
- Outputs:
  - miso = tx_sh[NUM_BITS-1] when state != IDLE, else 0.
  - miso_oe = ~cs_s, registered.
  - busy = (state != IDLE).
- FIFOs:
  - Host push/pop in the same cycle as an internal pop/push is legal.
  - new_data when tx_full is ignored; read_imp when rx_empty is ignored.
  - data_out is valid whenever rx_empty=0.
- Widths: bit_cnt has width $clog2(NUM_BITS+1); bit_cnt never wraps.

Decomposition:
- Shared package/include: state encodings (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10) and the default IDLE_WORD constant.
- Reuse the existing zrb_sync_fifo #(FIFO_AW, NUM_BITS) twice, once for TX and once for RX.
- One new sub-module, zrb_sync_2ff: a 2-flop synchroniser with asynchronous active-low reset and a reset-value parameter, instantiated three times.

Test Plan:
- Preload TX with 8'hA5. Master sends 8'h3C, sck half-period 8 clk.
  - Required: miso bits 1,0,1,0,0,1,0,1 observed at the master's sck rises.
  - Required: rx_empty falls, data_out=8'h3C, overrun=underrun=aborted=0.
- Preload TX with 8'h11 and 8'h22. Master sends 8'hF0, 8'h0F back to back under one cs_n.
  - Required: master receives 8'h11 then 8'h22; RX FIFO holds 8'hF0 then 8'h0F.
- TX FIFO empty, master sends 8'h55.
  - Required: miso returns 8'hFF and underrun pulses once.
  - Required: RX gets 8'h55.
- RX FIFO full (4 words, no reads), master sends a 5th word 8'h99.
  - Required: overrun pulses once, FIFO contents unchanged, rx_full stays 1.
- cs_n raised after 3 sck periods.
  - Required: aborted pulses, nothing pushed to RX, state=IDLE, miso_oe=0 within 3 clk.
  - Required: next full frame is received correctly.
- Assert reset mid-frame.
  - Required: immediately miso=0, miso_oe=0, busy=0, all FIFOs empty; no pulse outputs after release.
